// File: rtl/cp0_exc_ctrl.sv
// CP0 exception controller: latches edge-triggered exception requests, takes
// the highest-priority unmasked one into a nested context stack, and serves
// MTC0/MFC0/ERET accesses to its control registers.
//
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   inst, enable    current instruction and its CP0-operation qualifier
//   pc_in           PC saved as EPC when an exception is taken
//   din             MTC0 write data
//   exp_src         level exception requests (rising edge sets pending)
//   ex_reg_write    GPR write for MFC0 (~inst[23])
//   is_eret         ERET decoded this cycle
//   has_exp         exception taken this cycle (combinational)
//   vec_out         handler vector of the source being taken
//   pc_out          EPC of the top stack entry (ERET target)
//   exp_block       Status[0]
//   dout            MFC0 read data
module cp0_exc_ctrl #(
  parameter int unsigned NUM_SRC     = 8,
  parameter int unsigned STACK_DEPTH = 4,
  parameter logic [31:0] VEC_BASE    = 32'h0000_0080,
  parameter logic [31:0] VEC_STRIDE  = 32'h0000_0020
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        inst,
  input  logic               enable,
  input  logic [31:0]        pc_in,
  input  logic [31:0]        din,
  input  logic [NUM_SRC-1:0] exp_src,
  output logic               ex_reg_write,
  output logic               is_eret,
  output logic               has_exp,
  output logic [31:0]        vec_out,
  output logic [31:0]        pc_out,
  output logic               exp_block,
  output logic [31:0]        dout
);

  localparam int unsigned IDX_W   = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned CAUSE_W = $clog2(NUM_SRC + 1);
  localparam int unsigned DEP_W   = $clog2(STACK_DEPTH + 1);
  localparam int unsigned STK_N   = 1 << DEP_W;

  localparam logic [5:0] ERET_FUNCT = 6'b011000;
  localparam logic [2:0] SEL_EPC    = 3'd0;
  localparam logic [2:0] SEL_STATUS = 3'd1;
  localparam logic [2:0] SEL_MASK   = 3'd2;
  localparam logic [2:0] SEL_CAUSE  = 3'd3;
  localparam logic [2:0] SEL_PEND   = 3'd4;
  localparam logic [2:0] SEL_DEPTH  = 3'd5;

  logic [NUM_SRC-1:0] pending, mask, prev_src, src_edge, eligible, pend_nxt;
  logic               armed, status;
  logic [CAUSE_W-1:0] cause, cause_take;
  logic [DEP_W-1:0]   depth, top, below;
  logic [IDX_W-1:0]   idx;
  logic               wr, take, pop;
  logic [2:0]         sel;
  logic [31:0]        epc_top;

  // Stack storage is padded to a power of two so the depth counter indexes it directly.
  logic [31:0]        stk_epc   [STK_N];
  logic [CAUSE_W-1:0] stk_cause [STK_N];
  logic               stk_blk   [STK_N];

  logic unused_inst;
  assign unused_inst = ^{inst[31:24], inst[22:14], inst[10:6]};

  assign is_eret      = enable & (inst[5:0] == ERET_FUNCT);
  assign ex_reg_write = ~inst[23];
  assign sel          = inst[13:11];
  assign wr           = enable & inst[23] & ~is_eret;

  // armed masks the first edge after reset so a request already high is not an edge.
  assign src_edge = exp_src & ~prev_src & {NUM_SRC{armed}};
  assign eligible = pending & ~mask;
  assign top      = depth - DEP_W'(1);
  assign below    = depth - DEP_W'(2);

  // Lowest eligible index wins.
  always_comb begin
    idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) idx = IDX_W'(i);
    end
  end

  assign take       = (|eligible) & ~status & (depth < DEP_W'(STACK_DEPTH)) & ~is_eret;
  assign pop        = is_eret & (depth != '0);
  assign cause_take = CAUSE_W'(idx) + CAUSE_W'(1);

  assign has_exp   = take;
  assign vec_out   = take ? (VEC_BASE + 32'(idx) * VEC_STRIDE) : 32'h0;
  assign epc_top   = (depth != '0) ? stk_epc[top] : 32'h0;
  assign pc_out    = epc_top;
  assign exp_block = status;

  // Pending next value: W1C and take-clear first, so a new edge on the same bit wins.
  always_comb begin
    pend_nxt = pending;
    if (wr && (sel == SEL_PEND)) pend_nxt = pend_nxt & ~din[NUM_SRC-1:0];
    if (take) pend_nxt[idx] = 1'b0;
    pend_nxt = pend_nxt | src_edge;
  end

  // MFC0 read mux.
  always_comb begin
    dout = 32'h0;
    case (sel)
      SEL_EPC:    dout = epc_top;
      SEL_STATUS: dout = {31'h0, status};
      SEL_MASK:   dout = 32'(mask);
      SEL_CAUSE:  dout = 32'(cause);
      SEL_PEND:   dout = 32'(pending);
      SEL_DEPTH:  dout = 32'(depth);
      default:    dout = 32'h0;
    endcase
  end

  // Register and stack update; take beats MTC0 on Status/EPC, ERET excludes both.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending  <= '0;
      mask     <= '0;
      prev_src <= '0;
      armed    <= 1'b0;
      status   <= 1'b0;
      cause    <= '0;
      depth    <= '0;
      for (int i = 0; i < int'(STK_N); i++) begin
        stk_epc[i]   <= 32'h0;
        stk_cause[i] <= '0;
        stk_blk[i]   <= 1'b0;
      end
    end else begin
      armed    <= 1'b1;
      prev_src <= exp_src;
      pending  <= pend_nxt;
      if (wr && (sel == SEL_MASK)) mask <= din[NUM_SRC-1:0];
      if (take) begin
        stk_epc[depth]   <= pc_in;
        stk_cause[depth] <= cause_take;
        stk_blk[depth]   <= status;
        depth            <= depth + DEP_W'(1);
        status           <= 1'b1;
        cause            <= cause_take;
      end else if (pop) begin
        status <= stk_blk[top];
        cause  <= (depth > DEP_W'(1)) ? stk_cause[below] : '0;
        depth  <= top;
      end else begin
        if (wr && (sel == SEL_STATUS)) status <= din[0];
        if (wr && (sel == SEL_EPC) && (depth != '0)) stk_epc[top] <= din;
      end
    end
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Bench for cp0_exc_ctrl: directed stimulus pushes expected takes and MFC0
// reads into queues; a negedge monitor pops and compares when the DUT takes
// an exception or a read is presented.
module tb_cp0_exc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] inst, pc_in, din;
  logic        enable;
  logic [7:0]  exp_src;
  logic        ex_reg_write, is_eret, has_exp, exp_block;
  logic [31:0] vec_out, pc_out, dout;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [31:0] dout;
    logic [31:0] pc;
    logic        blk;
  } rd_t;

  rd_t         rd_q[$];
  logic [31:0] take_q[$];
  rd_t         r;
  logic [31:0] ev;

  cp0_exc_ctrl dut (
    .clk(clk), .reset(reset), .inst(inst), .enable(enable), .pc_in(pc_in),
    .din(din), .exp_src(exp_src), .ex_reg_write(ex_reg_write), .is_eret(is_eret),
    .has_exp(has_exp), .vec_out(vec_out), .pc_out(pc_out), .exp_block(exp_block),
    .dout(dout)
  );

  always #5 clk = ~clk;

  // Monitor
  always @(negedge clk) begin
    if (reset) begin
      if (has_exp) begin
        checks++;
        if (take_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_take vec_out=%h", vec_out);
        end else begin
          ev = take_q.pop_front();
          if (vec_out !== ev) begin
            failures++;
            $display("FAIL take_vec got=%h exp=%h", vec_out, ev);
          end
        end
      end
      if (enable && (inst[5:0] == 6'h18)) begin
        checks++;
        if (is_eret !== 1'b1) begin
          failures++;
          $display("FAIL is_eret got=%b exp=1", is_eret);
        end
      end else if (enable && !inst[23]) begin
        checks++;
        if (rd_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_read dout=%h", dout);
        end else begin
          r = rd_q.pop_front();
          if (dout !== r.dout) begin
            failures++;
            $display("FAIL %s dout got=%h exp=%h", r.name, dout, r.dout);
          end
          checks++;
          if (pc_out !== r.pc) begin
            failures++;
            $display("FAIL %s pc_out got=%h exp=%h", r.name, pc_out, r.pc);
          end
          checks++;
          if (exp_block !== r.blk) begin
            failures++;
            $display("FAIL %s exp_block got=%b exp=%b", r.name, exp_block, r.blk);
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    enable = 1'b0;
    inst   = 32'h0;
    din    = 32'h0;
  endtask

  task automatic mfc0(input logic [2:0] s, input logic [31:0] d, input logic [31:0] p,
                      input logic b, input string n);
    rd_q.push_back(rd_t'{n, d, p, b});
    enable = 1'b1;
    inst   = 32'(s) << 11;
    cyc();
    idle();
  endtask

  task automatic mtc0(input logic [2:0] s, input logic [31:0] data);
    enable = 1'b1;
    inst   = (32'h1 << 23) | (32'(s) << 11);
    din    = data;
    cyc();
    idle();
  endtask

  task automatic eret();
    enable = 1'b1;
    inst   = 32'h0000_0018;
    cyc();
    idle();
  endtask

  task automatic pulse(input int b);
    exp_src[b] = 1'b1;
    cyc();
    exp_src[b] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    reset   = 1'b0;
    idle();
    pc_in   = 32'h0;
    exp_src = 8'h01;
    repeat (3) cyc();
    reset = 1'b1;

    // Request high across reset release is not an edge
    cyc();
    cyc();
    mfc0(3'd4, 32'h0, 32'h0, 1'b0, "rst_pending");
    mfc0(3'd5, 32'h0, 32'h0, 1'b0, "rst_depth");
    mfc0(3'd1, 32'h0, 32'h0, 1'b0, "rst_status");
    exp_src = 8'h00;
    cyc();

    // Single take of source 3
    pc_in = 32'h400;
    take_q.push_back(32'h0E0);
    pulse(3);
    cyc();
    mfc0(3'd3, 32'd4, 32'h400, 1'b1, "s3_cause");
    mfc0(3'd5, 32'd1, 32'h400, 1'b1, "s3_depth");
    mtc0(3'd0, 32'h404);
    mfc0(3'd0, 32'h404, 32'h404, 1'b1, "epc_write");
    eret();
    mfc0(3'd3, 32'h0, 32'h0, 1'b0, "s3_eret_cause");

    // EPC write ignored when stack empty
    mtc0(3'd0, 32'h1234);
    mfc0(3'd0, 32'h0, 32'h0, 1'b0, "epc_empty");

    // Simultaneous sources 1 and 5: priority, then second after ERET
    pc_in = 32'h500;
    take_q.push_back(32'h0A0);
    exp_src = 8'h22;
    cyc();
    exp_src = 8'h00;
    cyc();
    mfc0(3'd3, 32'd2, 32'h500, 1'b1, "pri_cause1");
    mfc0(3'd4, 32'h20, 32'h500, 1'b1, "pri_pending5");
    pc_in = 32'h600;
    take_q.push_back(32'h120);
    eret();
    cyc();
    mfc0(3'd3, 32'd6, 32'h600, 1'b1, "pri_cause5");
    mfc0(3'd5, 32'd1, 32'h600, 1'b1, "pri_depth");
    eret();
    mfc0(3'd5, 32'd0, 32'h0, 1'b0, "pri_done");

    // Nested takes to full depth
    for (int k = 0; k < 4; k++) begin
      pc_in = 32'h10 * 32'(k + 1);
      take_q.push_back(32'h080);
      pulse(0);
      cyc();
      mtc0(3'd1, 32'h0);
    end
    pulse(0);
    cyc();
    mfc0(3'd5, 32'd4, 32'h40, 1'b0, "full_depth");
    mfc0(3'd4, 32'h01, 32'h40, 1'b0, "full_pending");
    mtc0(3'd4, 32'h01);
    mfc0(3'd4, 32'h0, 32'h40, 1'b0, "w1c_pending");
    for (int k = 3; k >= 0; k--) begin
      mfc0(3'd0, 32'h10 * 32'(k + 1), 32'h10 * 32'(k + 1), 1'b0, "nest_epc");
      eret();
    end
    mfc0(3'd0, 32'h0, 32'h0, 1'b0, "nest_empty");
    eret();
    mfc0(3'd5, 32'h0, 32'h0, 1'b0, "eret_empty");

    // Masked source, then unmask
    mtc0(3'd2, 32'h04);
    pulse(2);
    cyc();
    mfc0(3'd4, 32'h04, 32'h0, 1'b0, "mask_pending");
    pc_in = 32'h700;
    take_q.push_back(32'h0C0);
    mtc0(3'd2, 32'h0);
    cyc();
    mfc0(3'd3, 32'd3, 32'h700, 1'b1, "unmask_cause");
    mfc0(3'd2, 32'h0, 32'h700, 1'b1, "unmask_mask");
    eret();

    // Edge and W1C on same bit: set wins
    mtc0(3'd2, 32'h40);
    pulse(6);
    mfc0(3'd4, 32'h40, 32'h0, 1'b0, "set_pending6");
    exp_src[6] = 1'b1;
    mtc0(3'd4, 32'h40);
    exp_src[6] = 1'b0;
    mfc0(3'd4, 32'h40, 32'h0, 1'b0, "set_wins");
    mtc0(3'd4, 32'h40);
    mfc0(3'd4, 32'h0, 32'h0, 1'b0, "w1c_only");
    mtc0(3'd2, 32'h0);

    // Take and Status write in same cycle: take wins
    pc_in = 32'h800;
    take_q.push_back(32'h100);
    pulse(4);
    mtc0(3'd1, 32'h0);
    mfc0(3'd1, 32'h1, 32'h800, 1'b1, "take_vs_mtc0");
    eret();
    mfc0(3'd1, 32'h0, 32'h0, 1'b0, "status_restored");

    // Reset mid-handler at depth 2
    pc_in = 32'h900;
    take_q.push_back(32'h080);
    pulse(0);
    cyc();
    mtc0(3'd1, 32'h0);
    pc_in = 32'h910;
    take_q.push_back(32'h080);
    pulse(0);
    cyc();
    mfc0(3'd5, 32'd2, 32'h910, 1'b1, "pre_rst_depth");
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    for (int s = 0; s < 8; s++) begin
      mfc0(3'(s), 32'h0, 32'h0, 1'b0, "post_rst");
    end

    repeat (3) cyc();
    checks++;
    if (take_q.size() != 0 || rd_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain takes_left=%0d reads_left=%0d exp=0", take_q.size(), rd_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
